// File: rtl/dwconv_kx1_window_streamer_if.sv
// Handshake bundle for the KHx1 depthwise window streamer.
// The pixel input stream and the window output stream share one interface:
// 'slave' is the streamer's view, 'master' is the view of the environment
// that produces pixels and consumes windows.
interface dwconv_kx1_window_streamer_if #(
  parameter int DATA_W   = 32,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int KH       = 3,
  parameter int CHANNELS = 8
) ();
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [KH*DATA_W-1:0] out_taps;
  logic [CHAN_W-1:0]    out_chan;
  logic [ROW_W-1:0]     out_row;
  logic [COL_W-1:0]     out_col;
  logic                 frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_taps, out_chan, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_taps, out_chan, out_row, out_col, frame_done
  );
endinterface

// File: rtl/dwconv_kx1_window_streamer.sv
// KHx1 depthwise window streamer: buffers KH-1 rows of a raster-order plane
// and emits one vertical KH-tap window per (strided) output position.
// Optional feature macro: DWSTREAM_STALL_CNT_EN adds a saturating stall
// counter (stall_cnt) with a synchronous clear input (stall_clr).
module dwconv_kx1_window_streamer #(
  parameter int DATA_W   = 32,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16,
  parameter int KH       = 3,
  parameter int STRIDE   = 1,
  parameter int CHANNELS = 8
) (
  input logic clk,
  input logic rst,
  dwconv_kx1_window_streamer_if.slave bus
`ifdef DWSTREAM_STALL_CNT_EN
  ,
  input  logic        stall_clr,
  output logic [31:0] stall_cnt
`endif
);
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LB_ROWS = KH - 1;

  typedef enum logic [0:0] {FILL = 1'b0, STREAM = 1'b1} state_e;

  state_e               state_q;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [CHAN_W-1:0]    chan_q, chan_d;
  logic                 out_valid_q;
  logic                 frame_done_q;
  logic [KH*DATA_W-1:0] out_taps_q;
  logic [CHAN_W-1:0]    out_chan_q;
  logic [ROW_W-1:0]     out_row_q;
  logic [COL_W-1:0]     out_col_q;

  // Line buffer: lb_q[0] holds the oldest stored row, lb_q[LB_ROWS-1] the newest.
  logic [DATA_W-1:0]    lb_q [LB_ROWS][IMG_W];

  logic                 in_ready_s;
  logic                 accept_s;
  logic                 last_col_s;
  logic                 last_row_s;
  logic                 last_pix_s;
  logic                 phase_ok_s;
  logic                 emit_s;
  logic [ROW_W-1:0]     row_rel_s;
  logic [ROW_W-1:0]     out_row_s;
  logic [COL_W-1:0]     out_col_s;
  logic [KH*DATA_W-1:0] window_s;

  // No skid buffer: a held window blocks the input directly.
  assign in_ready_s = !out_valid_q || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign last_col_s = (col_q == COL_W'(IMG_W - 1));
  assign last_row_s = (row_q == ROW_W'(IMG_H - 1));
  assign last_pix_s = last_col_s && last_row_s;

  // Row offset from the first full window row; only meaningful in STREAM.
  assign row_rel_s  = row_q - ROW_W'(KH - 1);
  assign phase_ok_s = ((int'(row_rel_s) % STRIDE) == 0) && ((int'(col_q) % STRIDE) == 0);
  assign emit_s     = accept_s && (state_q == STREAM) && phase_ok_s;
  assign out_row_s  = ROW_W'(int'(row_rel_s) / STRIDE);
  assign out_col_s  = COL_W'(int'(col_q) / STRIDE);

  // Assemble the window: stored column words (oldest first) topped by the incoming pixel.
  always_comb begin
    window_s = {(KH*DATA_W){1'b0}};
    for (int k = 0; k < LB_ROWS; k++) begin
      window_s[k*DATA_W +: DATA_W] = lb_q[k][col_q];
    end
    window_s[LB_ROWS*DATA_W +: DATA_W] = bus.in_data;
  end

  // Raster position that follows the current pixel (col fastest, then row, then channel).
  always_comb begin
    col_d  = col_q + COL_W'(1);
    row_d  = row_q;
    chan_d = chan_q;
    if (last_col_s) begin
      col_d = {COL_W{1'b0}};
      if (last_row_s) begin
        row_d = {ROW_W{1'b0}};
        if (chan_q == CHAN_W'(CHANNELS - 1)) begin
          chan_d = {CHAN_W{1'b0}};
        end else begin
          chan_d = chan_q + CHAN_W'(1);
        end
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end else begin
      col_d = col_q + COL_W'(1);
    end
  end

  // Fill/stream sequencing, raster counters and the registered output window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      col_q        <= {COL_W{1'b0}};
      row_q        <= {ROW_W{1'b0}};
      chan_q       <= {CHAN_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_taps_q   <= {(KH*DATA_W){1'b0}};
      out_chan_q   <= {CHAN_W{1'b0}};
      out_row_q    <= {ROW_W{1'b0}};
      out_col_q    <= {COL_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept_s && last_pix_s;
      if (accept_s) begin
        col_q  <= col_d;
        row_q  <= row_d;
        chan_q <= chan_d;
        case (state_q)
          FILL:    if (last_col_s && (row_q == ROW_W'(KH - 2))) state_q <= STREAM;
          STREAM:  if (last_pix_s) state_q <= FILL;
          default: state_q <= FILL;
        endcase
      end
      // A new window may replace one that is handed off in the same cycle.
      if (emit_s) begin
        out_valid_q <= 1'b1;
        out_taps_q  <= window_s;
        out_chan_q  <= chan_q;
        out_row_q   <= out_row_s;
        out_col_q   <= out_col_s;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Column shift of the line buffer on every accepted pixel; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int j = 0; j < LB_ROWS - 1; j++) begin
        lb_q[j][col_q] <= lb_q[j+1][col_q];
      end
      lb_q[LB_ROWS-1][col_q] <= bus.in_data;
    end
  end

`ifdef DWSTREAM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where a window waits on the consumer; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (stall_clr) begin
      stall_cnt_q <= 32'd0;
    end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_taps   = out_taps_q;
  assign bus.out_chan   = out_chan_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dwconv_kx1_window_streamer.sv
// Self-checking bench for dwconv_kx1_window_streamer (5x5 planes, KH=3, stride 2,
// 2 channels). Expected windows come from an im2col-style model that walks the
// output grid of each queued plane.
module tb_dwconv_kx1_window_streamer;
  localparam int DATA_W   = 16;
  localparam int IMG_W    = 5;
  localparam int IMG_H    = 5;
  localparam int KH       = 3;
  localparam int STRIDE   = 2;
  localparam int CHANNELS = 2;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int WIN_PER_PLANE = ((IMG_H - KH) / STRIDE + 1) * ((IMG_W + STRIDE - 1) / STRIDE);
  localparam logic [63:0] RAMP_LAST_TAPS = {16'd0, 16'd24, 16'd19, 16'd14};

  typedef struct {
    logic [KH*DATA_W-1:0] taps;
    int chan;
    int row;
    int col;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dwconv_kx1_window_streamer_if #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .KH(KH), .CHANNELS(CHANNELS)
  ) bus ();

`ifdef DWSTREAM_STALL_CNT_EN
  logic        stall_clr = 1'b0;
  logic [31:0] stall_cnt;
`endif

  dwconv_kx1_window_streamer #(
    .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .KH(KH),
    .STRIDE(STRIDE), .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DWSTREAM_STALL_CNT_EN
    ,
    .stall_clr(stall_clr),
    .stall_cnt(stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // model / monitor state
  logic [DATA_W-1:0] px_q[$];
  win_t exp_q[$];
  int   next_chan = 0;
  int   acc_idx = 0;
  bit   mon_en = 1'b0;
  bit   exp_valid_next = 1'b0;
  bit   exp_fd_next = 1'b0;
  bit   held = 1'b0;
  logic [KH*DATA_W-1:0] prev_taps;
  logic [63:0] prev_pos;
  logic [63:0] last_taps = 64'd0;
  logic [63:0] last_pos = 64'd0;
  int   win_seen = 0;
  int   frames_seen = 0;
  int   full_planes = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue one plane and derive its expected windows by walking the output grid.
  task automatic queue_plane(input bit ramp);
    logic [DATA_W-1:0] pix [IMG_H][IMG_W];
    win_t w;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        pix[r][c] = ramp ? DATA_W'(IMG_W * r + c) : DATA_W'($urandom);
        px_q.push_back(pix[r][c]);
      end
    for (int orow = 0; orow * STRIDE + KH - 1 < IMG_H; orow++)
      for (int ocol = 0; ocol * STRIDE < IMG_W; ocol++) begin
        for (int k = 0; k < KH; k++) w.taps[k*DATA_W +: DATA_W] = pix[orow*STRIDE + k][ocol*STRIDE];
        w.chan = next_chan;
        w.row  = orow;
        w.col  = ocol;
        exp_q.push_back(w);
      end
    next_chan = (next_chan + 1) % CHANNELS;
  endtask

  task automatic drive(input int in_pct, input int rdy_pct);
    bus.in_valid  = (px_q.size() > 0) && ($urandom_range(99) < in_pct);
    bus.in_data   = (px_q.size() > 0) ? px_q[0] : DATA_W'(0);
    bus.out_ready = ($urandom_range(99) < rdy_pct);
  endtask

  // One clock: check at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    int r;
    int c;
    win_t w;
    @(negedge clk);
    if (mon_en) begin
      check_val("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (exp_valid_next) check_val("latency", 64'(bus.out_valid), 64'(1));
      check_val("frame_done", 64'(bus.frame_done), 64'(exp_fd_next));
      if (held) begin
        check_val("hold_valid", 64'(bus.out_valid), 64'(1));
        check_val("hold_taps", 64'(bus.out_taps), 64'(prev_taps));
        check_val("hold_pos", {bus.out_chan, bus.out_row, bus.out_col}, prev_pos);
      end
      if (bus.out_valid && bus.out_ready) begin
        check_val("win_avail", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check_val("win_taps", 64'(bus.out_taps), 64'(w.taps));
          check_val("win_chan", 64'(bus.out_chan), 64'(w.chan));
          check_val("win_row", 64'(bus.out_row), 64'(w.row));
          check_val("win_col", 64'(bus.out_col), 64'(w.col));
          win_seen++;
          last_taps = 64'(bus.out_taps);
          last_pos  = {bus.out_chan, bus.out_row, bus.out_col};
        end
      end
      if (bus.frame_done) frames_seen++;
    end
    held      = bus.out_valid && !bus.out_ready;
    prev_taps = bus.out_taps;
    prev_pos  = {bus.out_chan, bus.out_row, bus.out_col};
    exp_valid_next = 1'b0;
    exp_fd_next    = 1'b0;
    if (mon_en && bus.in_valid && bus.in_ready) begin
      r = acc_idx / IMG_W;
      c = acc_idx % IMG_W;
      exp_valid_next = (r >= KH - 1) && ((r - (KH - 1)) % STRIDE == 0) && (c % STRIDE == 0);
      exp_fd_next    = (acc_idx == NPIX - 1);
      if (acc_idx == NPIX - 1) full_planes++;
      acc_idx = (acc_idx + 1) % NPIX;
      void'(px_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    px_q.delete();
    exp_q.delete();
    acc_idx = 0;
    next_chan = 0;
    held = 1'b0;
    exp_valid_next = 1'b0;
    exp_fd_next = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic run_drain(input int in_pct, input int rdy_pct, input int budget);
    int cyc = 0;
    while ((px_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      drive(in_pct, rdy_pct);
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_val("drain_timeout", 64'(px_q.size() + exp_q.size()), 64'(0));
  endtask

  initial begin
    int cyc;
    bit stalled;
    bus.in_valid  = 1'b0;
    bus.in_data   = DATA_W'(0);
    bus.out_ready = 1'b0;

    // reset values
    do_reset();
    check_val("rst_valid", 64'(bus.out_valid), 64'(0));
    check_val("rst_taps", 64'(bus.out_taps), 64'(0));
    check_val("rst_pos", {bus.out_chan, bus.out_row, bus.out_col}, 64'(0));
    check_val("rst_frame_done", 64'(bus.frame_done), 64'(0));
    check_val("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // ramp plane, free-flowing: 6 windows, last {14,19,24} at row 1 col 2
    queue_plane(1'b1);
    run_drain(100, 100, 500);
    check_val("ramp_win_count", 64'(win_seen), 64'(WIN_PER_PLANE));
    check_val("ramp_last_taps", last_taps, RAMP_LAST_TAPS);
    check_val("ramp_last_pos", last_pos, {CHAN_W_PAD(0), 64'(0)} | 64'({3'd1, 3'd2}));
    check_val("ramp_frames", 64'(frames_seen), 64'(1));

    // backpressure: hold the first window of the plane for 5 cycles
    queue_plane(1'b1);
    stalled = 1'b0;
    cyc = 0;
    while ((px_q.size() > 0 || exp_q.size() > 0) && cyc < 500) begin
      drive(100, 100);
      if (!stalled && bus.out_valid) begin
        stalled = 1'b1;
        for (int i = 0; i < 5; i++) begin
          bus.out_ready = 1'b0;
          tick();
          check_val("bp_in_ready", 64'(bus.in_ready), 64'(0));
        end
`ifdef DWSTREAM_STALL_CNT_EN
        check_val("stall_cnt", 64'(stall_cnt), 64'(5));
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check_val("stall_clr", 64'(stall_cnt), 64'(0));
`endif
        bus.out_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_val("bp_drain", 64'(px_q.size() + exp_q.size()), 64'(0));
    check_val("bp_stalled", 64'(stalled), 64'(1));
    check_val("bp_win_count", 64'(win_seen), 64'(2 * WIN_PER_PLANE));
    check_val("bp_frames", 64'(frames_seen), 64'(2));

    // reset mid-plane while a window is pending
    queue_plane(1'b1);
    cyc = 0;
    while (acc_idx < 11 && cyc < 100) begin
      drive(100, 100);
      tick();
      cyc++;
    end
    check_val("mid_accepts", 64'(acc_idx), 64'(11));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check_val("mid_pre_valid", 64'(bus.out_valid), 64'(1));
    do_reset();
    check_val("mid_post_valid", 64'(bus.out_valid), 64'(0));
    check_val("mid_post_in_ready", 64'(bus.in_ready), 64'(1));
    queue_plane(1'b1);
    run_drain(100, 100, 500);
    check_val("mid_win_count", 64'(win_seen), 64'(3 * WIN_PER_PLANE));
    check_val("mid_last_taps", last_taps, RAMP_LAST_TAPS);

    // random handshakes over many planes and channel wraps
    for (int p = 0; p < 16; p++) queue_plane(1'b0);
    run_drain(50, 50, 20000);

    check_val("total_windows", 64'(win_seen), 64'(full_planes * WIN_PER_PLANE));
    check_val("total_frames", 64'(frames_seen), 64'(full_planes));
    check_val("total_planes", 64'(full_planes), 64'(19));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Position word as {chan,row,col} with the DUT's field widths (chan=0 here).
  function automatic logic [63:0] CHAN_W_PAD(input int v);
    return 64'(v);
  endfunction
endmodule
